mul_booth_seq: RTL and testbench

Sequential signed radix-2 Booth multiplier for the datapath's MUL instruction, the multiplicative counterpart of the combinational divider. It takes two signed WIDTH-bit operands, runs one Booth step per clock, and returns the 2·WIDTH-bit product as {HI, LO}. The result feeds the HI/LO register pair in the same packing the divider uses: upper half to HI, lower half to LO. The control unit drives it with a start/busy/done handshake.

---
 rtl/mul_booth_seq.sv | 138 +++++++++++++
 tb/tb_mul_booth_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_booth_seq.sv
// Sequential signed radix-2 Booth multiplier.
// One Booth step per clock. WIDTH steps produce the 2*WIDTH-bit product as {HI, LO}.
// The control unit drives it through a start/busy/done handshake.
module mul_booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // A and M carry one extra sign bit so that A - M cannot overflow
  // when the multiplicand is the most negative value.
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 accept;
  logic                 last_step;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       acc_sh;
  logic [WIDTH-1:0]     q_sh;

  assign accept    = (state_q == ST_IDLE) && start;
  assign last_step = (state_q == ST_RUN) && (count_q == LAST_STEP);

  // State register. Reset has priority over a coincident start.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last step,
  // DONE -> IDLE unconditionally.
  // NOTE: assigning a default before the case keeps every path driven, so no
  // latch is inferred when a branch leaves a signal untouched.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)     state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output decode. Both outputs come straight from the state register,
  // so there is no combinational path from any input.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // One Booth step: add or subtract M depending on {Q[0], Q-1}, then shift
  // {A, Q, Q-1} right arithmetically by one.
  always_comb begin
    sum = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
    acc_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh   = {sum[0], q_q[WIDTH-1:1]};
  end

  // Datapath next-state: load operands on accept, step while running, and
  // publish the product only once the final step has been taken.
  always_comb begin
    acc_d    = acc_q;
    m_d      = m_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    count_d  = count_q;
    result_d = result_q;
    if (accept) begin
      acc_d   = '0;
      m_d     = {a[WIDTH-1], a};
      q_d     = b;
      qm1_d   = 1'b0;
      count_d = '0;
    end else if (state_q == ST_RUN) begin
      acc_d   = acc_sh;
      q_d     = q_sh;
      qm1_d   = q_q[0];
      count_d = count_q + CW'(1);
      if (last_step) begin
        result_d = {acc_sh[WIDTH-1:0], q_sh};
      end
    end
  end

  // Datapath registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      acc_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      m_q      <= m_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq: directed products with hand-computed
// results, handshake timing, busy protection, reset behaviour and a short
// corner-biased random batch checked against a signed 64-bit reference.
module tb_mul_booth_seq;

  localparam int W = 32;

  logic           clk;
  logic           clr_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  int n_checks;
  int n_fail;

  mul_booth_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction. The caller must leave the DUT in IDLE.
  task automatic run_mul(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [63:0] exp);
    int lat;
    logic busy_ok;
    logic [63:0] got;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;
    check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= W + 4 && lat == 0; k++) begin
      tick();
      if (done) lat = k;
      else if (!busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 64'(lat), 64'(W));
    check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " result"}, result, exp);
    got = result;
    tick();
    check({tag, " done_width"}, 64'(done), 64'd0);
    check({tag, " result_hold"}, result, got);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] av;
    logic [31:0] bv;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n_done;
    int first_done;
    int second_done;
    logic busy_ok;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rexp;

    n_checks = 0;
    n_fail   = 0;
    clr_n = 1'b0; start = 1'b0; a = '0; b = '0;

    vecs[0] = '{"6x7",        32'd6,          32'd7,          64'h0000_0000_0000_002A};
    vecs[1] = '{"m6x7",       32'hFFFF_FFFA,  32'd7,          64'hFFFF_FFFF_FFFF_FFD6};
    vecs[2] = '{"m1xm1",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
    vecs[3] = '{"minxmin",    32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[4] = '{"maxxmax",    32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
    vecs[5] = '{"minx1",      32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000};
    vecs[6] = '{"minxm1",     32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000};
    vecs[7] = '{"maxxmin",    32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000};
    vecs[8] = '{"0xmax",      32'd0,          32'h7FFF_FFFF,  64'h0000_0000_0000_0000};
    vecs[9] = '{"12345xm1000",32'd12345,      32'hFFFF_FC18,  64'hFFFF_FFFF_FF43_A158};

    // Reset state.
    tick();
    tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    clr_n = 1'b1;
    tick();

    // Directed products.
    foreach (vecs[i]) run_mul(vecs[i].tag, vecs[i].av, vecs[i].bv, vecs[i].exp);

    // Busy protection: a second start mid-run with wandering operands is ignored.
    a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= W + 3; k++) begin
      a = (k == 10) ? 32'd9 : $urandom;
      b = (k == 10) ? 32'd9 : $urandom;
      start = (k == 10);
      tick();
      if (done) n_done++;
      if (k < W && !busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check("busyprot done_count", 64'(n_done), 64'd1);
    check("busyprot busy_held", 64'(busy_ok), 64'd1);
    check("busyprot result", result, 64'd15);

    // Back-to-back: start held high is accepted again at the first IDLE edge.
    a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
    tick();
    first_done = 0;
    second_done = 0;
    for (int k = 1; k <= 2 * W + 10 && second_done == 0; k++) begin
      tick();
      if (done) begin
        if (first_done == 0) first_done = k;
        else second_done = k;
      end
    end
    start = 1'b0;
    check("b2b first_done", 64'(first_done), 64'(W));
    check("b2b second_done", 64'(second_done), 64'(2 * W + 2));
    check("b2b result", result, 64'hFFFF_FFFF_FFFF_FFFA);
    tick();

    // Reset mid-operation abandons the multiply.
    a = 32'd100; b = 32'd100; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 16; k++) tick();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", result, 64'd0);
    n_done = 0;
    for (int k = 0; k < W + 8; k++) begin
      tick();
      if (done) n_done++;
    end
    check("midreset no_done", 64'(n_done), 64'd0);
    run_mul("after_reset 2x3", 32'd2, 32'd3, 64'd6);

    // Reset coincident with start: nothing is accepted.
    clr_n = 1'b0; start = 1'b1; a = 32'd7; b = 32'd7;
    tick();
    clr_n = 1'b1; start = 1'b0;
    check("rst_start busy", 64'(busy), 64'd0);
    check("rst_start result", result, 64'd0);
    tick();
    check("rst_start busy_later", 64'(busy), 64'd0);

    // Corner-biased random batch against a signed 64-bit reference.
    for (int i = 0; i < 200; i++) begin
      ra = pick();
      rb = pick();
      rexp = 64'(longint'(signed'(ra)) * longint'(signed'(rb)));
      run_mul($sformatf("rand%0d", i), ra, rb, rexp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
